// File: rtl/grf_pkg.sv
// Shared widths and the writeback request record used by the GRF writeback arbiter.
package grf_pkg;

   localparam int REG_AW  = 5;
   localparam int DATA_W  = 32;
   localparam int REG_NUM = 32;
   localparam logic [REG_AW-1:0] ZERO_REG = 5'd0;

   typedef struct packed {
      logic [REG_AW-1:0] addr;
      logic [DATA_W-1:0] data;
      logic [DATA_W-1:0] pc;
   } wb_req_t;

endpackage

// File: rtl/grf_scoreboard.sv
// Per-register outstanding-write counters and the GRF read-hazard stall.
// With GRF_WB_ARB_BYPASS_EN defined, a last outstanding write that is committing now is forwarded instead of stalling.
module grf_scoreboard
   import grf_pkg::*;
#(
   parameter int CNT_W = 2
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              rsvValid,
   input  logic [REG_AW-1:0] rsvAddr,
   input  logic              commitEn,
   input  logic [REG_AW-1:0] commitAddr,
   input  logic [REG_AW-1:0] chkA1,
   input  logic [REG_AW-1:0] chkA2,
   output logic              stall,
   output logic              rsvOvf
`ifdef GRF_WB_ARB_BYPASS_EN
   ,output logic [1:0]       bypassSel
`endif
);

   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   logic [CNT_W-1:0]   cnt [REG_NUM];
   logic [REG_NUM-1:0] incVec;
   logic [REG_NUM-1:0] decVec;
   logic               haz1;
   logic               haz2;

   always_comb begin
      incVec = '0;
      decVec = '0;
      if (rsvValid) incVec[rsvAddr] = 1'b1;
      if (commitEn) decVec[commitAddr] = 1'b1;
      incVec[0] = 1'b0;
      decVec[0] = 1'b0;
   end

   // A reserve and a commit on the same register cancel; overflowing reserves are dropped but remembered.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int r = 0; r < REG_NUM; r++) cnt[r] <= '0;
         rsvOvf <= 1'b0;
      end else begin
         for (int r = 1; r < REG_NUM; r++) begin
            if (incVec[r] && !decVec[r]) begin
               if (cnt[r] != CNT_MAX) cnt[r] <= cnt[r] + 1'b1;
               else rsvOvf <= 1'b1;
            end else if (decVec[r] && !incVec[r]) begin
               if (cnt[r] != '0) cnt[r] <= cnt[r] - 1'b1;
            end
         end
      end
   end

`ifdef GRF_WB_ARB_BYPASS_EN
   logic commit1;
   logic commit2;

   always_comb begin
      commit1 = commitEn && (commitAddr == chkA1);
      commit2 = commitEn && (commitAddr == chkA2);
      haz1 = (chkA1 != ZERO_REG) && (cnt[chkA1] != '0)
             && !((cnt[chkA1] == CNT_W'(1)) && commit1);
      haz2 = (chkA2 != ZERO_REG) && (cnt[chkA2] != '0)
             && !((cnt[chkA2] == CNT_W'(1)) && commit2);
      bypassSel[0] = (chkA1 != ZERO_REG) && commit1;
      bypassSel[1] = (chkA2 != ZERO_REG) && commit2;
   end
`else
   always_comb begin
      haz1 = (chkA1 != ZERO_REG) && (cnt[chkA1] != '0);
      haz2 = (chkA2 != ZERO_REG) && (cnt[chkA2] != '0);
   end
`endif

   assign stall = haz1 || haz2;

endmodule

// File: rtl/grf_wb_arbiter.sv
// Round-robin arbiter sharing the GRF write port between the W stage and the multi-cycle unit.
// Optional forwarding port bypass_sel exists only when GRF_WB_ARB_BYPASS_EN is defined.
module grf_wb_arbiter
   import grf_pkg::*;
#(
   parameter int CNT_W   = 2,
   parameter int RR_INIT = 0
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              req0_valid,
   output logic              req0_ready,
   input  logic [REG_AW-1:0] req0_addr,
   input  logic [DATA_W-1:0] req0_data,
   input  logic [DATA_W-1:0] req0_pc,
   input  logic              req1_valid,
   output logic              req1_ready,
   input  logic [REG_AW-1:0] req1_addr,
   input  logic [DATA_W-1:0] req1_data,
   input  logic [DATA_W-1:0] req1_pc,
   input  logic              rsv_valid,
   input  logic [REG_AW-1:0] rsv_addr,
   input  logic [REG_AW-1:0] chk_a1,
   input  logic [REG_AW-1:0] chk_a2,
   output logic              stall,
   output logic [REG_AW-1:0] grfA3,
   output logic [DATA_W-1:0] grfWD,
   output logic              grfWriteEn,
   output logic [DATA_W-1:0] grfPC,
   output logic              rsv_ovf
`ifdef GRF_WB_ARB_BYPASS_EN
   ,output logic [1:0]       bypass_sel
`endif
);

   wb_req_t req0;
   wb_req_t req1;
   wb_req_t winner;
   logic    rrPtr;
   logic    grant0;
   logic    grant1;

   assign req0 = '{addr: req0_addr, data: req0_data, pc: req0_pc};
   assign req1 = '{addr: req1_addr, data: req1_data, pc: req1_pc};

   // The output register drains every cycle, so whichever requester is valid is granted at once.
   always_comb begin
      grant0 = req0_valid && (!req1_valid || !rrPtr);
      grant1 = req1_valid && (!req0_valid || rrPtr);
      winner = grant1 ? req1 : req0;
   end

   assign req0_ready = grant0;
   assign req1_ready = grant1;

   // On contention the pointer moves to the loser, bounding its wait to one cycle.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) rrPtr <= 1'(RR_INIT);
      else if (req0_valid && req1_valid) rrPtr <= grant0;
   end

   // Writes to $0 are accepted and recorded but never enable the GRF.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         grfWriteEn <= 1'b0;
         grfA3      <= '0;
         grfWD      <= '0;
         grfPC      <= '0;
      end else if (grant0 || grant1) begin
         grfWriteEn <= (winner.addr != ZERO_REG);
         grfA3      <= winner.addr;
         grfWD      <= winner.data;
         grfPC      <= winner.pc;
      end else begin
         grfWriteEn <= 1'b0;
      end
   end

   grf_scoreboard #(.CNT_W(CNT_W)) scoreboard (
      .clk        (clk),
      .reset      (reset),
      .rsvValid   (rsv_valid),
      .rsvAddr    (rsv_addr),
      .commitEn   (grfWriteEn),
      .commitAddr (grfA3),
      .chkA1      (chk_a1),
      .chkA2      (chk_a2),
      .stall      (stall),
      .rsvOvf     (rsv_ovf)
`ifdef GRF_WB_ARB_BYPASS_EN
      ,.bypassSel (bypass_sel)
`endif
   );

endmodule

// File: tb/tb_grf_wb_arbiter.sv
// Directed bench for grf_wb_arbiter: vector table for arbitration/commit/stall plus hand sequences for overflow and reset.
module tb_grf_wb_arbiter;

`ifdef GRF_WB_ARB_BYPASS_EN
   localparam bit BYP = 1'b1;
`else
   localparam bit BYP = 1'b0;
`endif

   logic        clk;
   logic        reset;
   logic        req0_valid, req0_ready;
   logic [4:0]  req0_addr;
   logic [31:0] req0_data, req0_pc;
   logic        req1_valid, req1_ready;
   logic [4:0]  req1_addr;
   logic [31:0] req1_data, req1_pc;
   logic        rsv_valid;
   logic [4:0]  rsv_addr;
   logic [4:0]  chk_a1, chk_a2;
   logic        stall;
   logic [4:0]  grfA3;
   logic [31:0] grfWD;
   logic        grfWriteEn;
   logic [31:0] grfPC;
   logic        rsv_ovf;
`ifdef GRF_WB_ARB_BYPASS_EN
   logic [1:0]  bypass_sel;
`endif

   int passCount = 0;
   int checkCount = 0;

   typedef struct {
      logic        v0;
      logic [4:0]  a0;
      logic [31:0] d0;
      logic [31:0] p0;
      logic        v1;
      logic [4:0]  a1;
      logic [31:0] d1;
      logic [31:0] p1;
      logic        rsvV;
      logic [4:0]  rsvA;
      logic [4:0]  c1;
      logic        r0;
      logic        r1;
      logic        we;
      logic [4:0]  a3;
      logic [31:0] wd;
      logic [31:0] pc;
      logic        st;
   } vec_t;

   vec_t vecs [16];

   grf_wb_arbiter #(.CNT_W(2), .RR_INIT(0)) dut (
      .clk        (clk),
      .reset      (reset),
      .req0_valid (req0_valid),
      .req0_ready (req0_ready),
      .req0_addr  (req0_addr),
      .req0_data  (req0_data),
      .req0_pc    (req0_pc),
      .req1_valid (req1_valid),
      .req1_ready (req1_ready),
      .req1_addr  (req1_addr),
      .req1_data  (req1_data),
      .req1_pc    (req1_pc),
      .rsv_valid  (rsv_valid),
      .rsv_addr   (rsv_addr),
      .chk_a1     (chk_a1),
      .chk_a2     (chk_a2),
      .stall      (stall),
      .grfA3      (grfA3),
      .grfWD      (grfWD),
      .grfWriteEn (grfWriteEn),
      .grfPC      (grfPC),
      .rsv_ovf    (rsv_ovf)
`ifdef GRF_WB_ARB_BYPASS_EN
      ,.bypass_sel (bypass_sel)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      checkCount++;
      if (actual === expected) passCount++;
      else $display("[TB] FAIL %s: got %h, wanted %h", name, actual, expected);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic setIdle();
      req0_valid = 1'b0; req0_addr = '0; req0_data = '0; req0_pc = '0;
      req1_valid = 1'b0; req1_addr = '0; req1_data = '0; req1_pc = '0;
      rsv_valid = 1'b0; rsv_addr = '0;
   endtask

   task automatic applyStimulus(input vec_t v);
      req0_valid = v.v0; req0_addr = v.a0; req0_data = v.d0; req0_pc = v.p0;
      req1_valid = v.v1; req1_addr = v.a1; req1_data = v.d1; req1_pc = v.p1;
      rsv_valid = v.rsvV; rsv_addr = v.rsvA;
      chk_a1 = v.c1; chk_a2 = '0;
   endtask

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation did not finish");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      // Row fields: v0 a0 d0 p0 | v1 a1 d1 p1 | rsvV rsvA c1 || r0 r1 we a3 wd pc stall
      vecs[0]  = '{1'b1, 5'd5, 32'h1234, 32'h3000, 1'b0, 5'd0, 32'h0, 32'h0, 1'b0, 5'd0, 5'd0,
                   1'b1, 1'b0, 1'b0, 5'd0, 32'h0, 32'h0, 1'b0};
      vecs[1]  = '{1'b1, 5'd5, 32'h1234, 32'h3000, 1'b0, 5'd0, 32'h0, 32'h0, 1'b0, 5'd0, 5'd0,
                   1'b1, 1'b0, 1'b1, 5'd5, 32'h1234, 32'h3000, 1'b0};
      vecs[2]  = vecs[1];
      vecs[3]  = '{1'b0, 5'd0, 32'h0, 32'h0, 1'b0, 5'd0, 32'h0, 32'h0, 1'b0, 5'd0, 5'd0,
                   1'b0, 1'b0, 1'b1, 5'd5, 32'h1234, 32'h3000, 1'b0};
      vecs[4]  = '{1'b1, 5'd1, 32'hA1, 32'h4001, 1'b1, 5'd2, 32'hB2, 32'h5002, 1'b0, 5'd0, 5'd0,
                   1'b1, 1'b0, 1'b0, 5'd5, 32'h1234, 32'h3000, 1'b0};
      vecs[5]  = '{1'b1, 5'd3, 32'hA3, 32'h4003, 1'b1, 5'd2, 32'hB2, 32'h5002, 1'b0, 5'd0, 5'd0,
                   1'b0, 1'b1, 1'b1, 5'd1, 32'hA1, 32'h4001, 1'b0};
      vecs[6]  = '{1'b1, 5'd3, 32'hA3, 32'h4003, 1'b1, 5'd4, 32'hB4, 32'h5004, 1'b0, 5'd0, 5'd0,
                   1'b1, 1'b0, 1'b1, 5'd2, 32'hB2, 32'h5002, 1'b0};
      vecs[7]  = '{1'b1, 5'd6, 32'hA6, 32'h4006, 1'b1, 5'd4, 32'hB4, 32'h5004, 1'b0, 5'd0, 5'd0,
                   1'b0, 1'b1, 1'b1, 5'd3, 32'hA3, 32'h4003, 1'b0};
      vecs[8]  = '{1'b1, 5'd6, 32'hA6, 32'h4006, 1'b0, 5'd0, 32'h0, 32'h0, 1'b0, 5'd0, 5'd0,
                   1'b1, 1'b0, 1'b1, 5'd4, 32'hB4, 32'h5004, 1'b0};
      vecs[9]  = '{1'b0, 5'd0, 32'h0, 32'h0, 1'b1, 5'd0, 32'hFFFF, 32'h5000, 1'b0, 5'd0, 5'd0,
                   1'b0, 1'b1, 1'b1, 5'd6, 32'hA6, 32'h4006, 1'b0};
      vecs[10] = '{1'b0, 5'd0, 32'h0, 32'h0, 1'b0, 5'd0, 32'h0, 32'h0, 1'b0, 5'd0, 5'd0,
                   1'b0, 1'b0, 1'b0, 5'd0, 32'hFFFF, 32'h5000, 1'b0};
      vecs[11] = '{1'b0, 5'd0, 32'h0, 32'h0, 1'b0, 5'd0, 32'h0, 32'h0, 1'b1, 5'd8, 5'd8,
                   1'b0, 1'b0, 1'b0, 5'd0, 32'hFFFF, 32'h5000, 1'b0};
      vecs[12] = '{1'b0, 5'd0, 32'h0, 32'h0, 1'b0, 5'd0, 32'h0, 32'h0, 1'b0, 5'd0, 5'd8,
                   1'b0, 1'b0, 1'b0, 5'd0, 32'hFFFF, 32'h5000, 1'b1};
      vecs[13] = '{1'b1, 5'd8, 32'hD8, 32'h4008, 1'b0, 5'd0, 32'h0, 32'h0, 1'b0, 5'd0, 5'd8,
                   1'b1, 1'b0, 1'b0, 5'd0, 32'hFFFF, 32'h5000, 1'b1};
      vecs[14] = '{1'b0, 5'd0, 32'h0, 32'h0, 1'b0, 5'd0, 32'h0, 32'h0, 1'b0, 5'd0, 5'd8,
                   1'b0, 1'b0, 1'b1, 5'd8, 32'hD8, 32'h4008, !BYP};
      vecs[15] = '{1'b0, 5'd0, 32'h0, 32'h0, 1'b0, 5'd0, 32'h0, 32'h0, 1'b0, 5'd0, 5'd8,
                   1'b0, 1'b0, 1'b0, 5'd8, 32'hD8, 32'h4008, 1'b0};

      reset = 1'b0;
      setIdle();
      chk_a1 = '0; chk_a2 = '0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      reset = 1'b1;
      #1;
      checkOutput("reset.we",    32'(grfWriteEn), 32'h0);
      checkOutput("reset.a3",    32'(grfA3),      32'h0);
      checkOutput("reset.wd",    grfWD,           32'h0);
      checkOutput("reset.pc",    grfPC,           32'h0);
      checkOutput("reset.stall", 32'(stall),      32'h0);
      checkOutput("reset.ovf",   32'(rsv_ovf),    32'h0);
      tick();

      for (int i = 0; i < 16; i++) begin
         applyStimulus(vecs[i]);
         #1;
         checkOutput($sformatf("row%0d.ready0", i), 32'(req0_ready), 32'(vecs[i].r0));
         checkOutput($sformatf("row%0d.ready1", i), 32'(req1_ready), 32'(vecs[i].r1));
         checkOutput($sformatf("row%0d.we", i),     32'(grfWriteEn), 32'(vecs[i].we));
         checkOutput($sformatf("row%0d.a3", i),     32'(grfA3),      32'(vecs[i].a3));
         checkOutput($sformatf("row%0d.wd", i),     grfWD,           vecs[i].wd);
         checkOutput($sformatf("row%0d.pc", i),     grfPC,           vecs[i].pc);
         checkOutput($sformatf("row%0d.stall", i),  32'(stall),      32'(vecs[i].st));
         tick();
      end

      // Saturating reservations on $9, then a cancelling reserve+commit pair.
      setIdle();
      chk_a1 = '0; chk_a2 = 5'd9;
      rsv_valid = 1'b1; rsv_addr = 5'd9;
      repeat (3) tick();
      #1;
      checkOutput("ovf.belowMax",  32'(rsv_ovf), 32'h0);
      checkOutput("ovf.stallA2",   32'(stall),   32'h1);
      tick();
      checkOutput("ovf.atMax",     32'(rsv_ovf), 32'h1);
      rsv_valid = 1'b0;
      req0_valid = 1'b1; req0_addr = 5'd9; req0_data = 32'hE9; req0_pc = 32'h6000;
      tick();
      req0_valid = 1'b0;
      rsv_valid = 1'b1; rsv_addr = 5'd9;
      #1;
      checkOutput("ovf.commitWe",  32'(grfWriteEn), 32'h1);
      checkOutput("ovf.commitA3",  32'(grfA3),      32'h9);
      tick();
      rsv_valid = 1'b0;
      req0_valid = 1'b1;
      tick();
      tick();
      #1;
      checkOutput("ovf.stallCnt2", 32'(stall), 32'h1);
      tick();
      req0_valid = 1'b0;
      #1;
      checkOutput("ovf.stallLastCommit", 32'(stall), 32'(!BYP));
`ifdef GRF_WB_ARB_BYPASS_EN
      checkOutput("ovf.bypassSel", 32'(bypass_sel), 32'h2);
`endif
      tick();
      checkOutput("ovf.stallDrained", 32'(stall),      32'h0);
      checkOutput("ovf.idleWe",       32'(grfWriteEn), 32'h0);
      checkOutput("ovf.sticky",       32'(rsv_ovf),    32'h1);

      // Asynchronous reset during a commit cycle.
      chk_a2 = '0; chk_a1 = 5'd10;
      rsv_valid = 1'b1; rsv_addr = 5'd10;
      req0_valid = 1'b1; req0_addr = 5'd7;  req0_data = 32'h77; req0_pc = 32'h7000;
      req1_valid = 1'b1; req1_addr = 5'd11; req1_data = 32'h1B; req1_pc = 32'h7100;
      tick();
      setIdle();
      #1;
      checkOutput("preReset.we",    32'(grfWriteEn), 32'h1);
      checkOutput("preReset.a3",    32'(grfA3),      32'h7);
      checkOutput("preReset.stall", 32'(stall),      32'h1);
      #1;
      reset = 1'b0;
      #1;
      checkOutput("midReset.we",    32'(grfWriteEn), 32'h0);
      checkOutput("midReset.a3",    32'(grfA3),      32'h0);
      checkOutput("midReset.wd",    grfWD,           32'h0);
      checkOutput("midReset.stall", 32'(stall),      32'h0);
      checkOutput("midReset.ovf",   32'(rsv_ovf),    32'h0);
      @(posedge clk);
      @(negedge clk);
      reset = 1'b1;
      tick();
      checkOutput("postReset.noCommit", 32'(grfWriteEn), 32'h0);
      checkOutput("postReset.stall",    32'(stall),      32'h0);
      req0_valid = 1'b1; req0_addr = 5'd7;  req0_data = 32'h77; req0_pc = 32'h7000;
      req1_valid = 1'b1; req1_addr = 5'd11; req1_data = 32'h1B; req1_pc = 32'h7100;
      #1;
      checkOutput("postReset.rrReady0", 32'(req0_ready), 32'h1);
      checkOutput("postReset.rrReady1", 32'(req1_ready), 32'h0);
      tick();
      req0_valid = 1'b0;
      #1;
      checkOutput("postReset.we",      32'(grfWriteEn), 32'h1);
      checkOutput("postReset.wd",      grfWD,           32'h77);
      checkOutput("postReset.ready1",  32'(req1_ready), 32'h1);
      tick();
      setIdle();
      checkOutput("postReset.loserA3", 32'(grfA3), 32'd11);
      checkOutput("postReset.loserWd", grfWD,      32'h1B);
      tick();

      $display("%0d/%0d checks passed", passCount, checkCount);
      $finish;
   end

endmodule

// File: doc/grf_wb_arbiter.md
Name: grf_wb_arbiter

Overview:
- Shares the single GRF write port between two writeback requesters: req0 is the main pipeline W stage, req1 is the multi-cycle mult/div/load unit.
- Registers the winning write into GRF write-port signals, so the GRF sees a one-cycle-delayed write.
- Keeps a per-register pending-write scoreboard, reserved at issue and released at commit.
- Drives the read-hazard stall for the GRF read ports.

Parameters:
- CNT_W, 2, width of per-register outstanding-write counter (max 2^CNT_W-1 outstanding)
- RR_INIT, 0, requester favoured first after reset (0 or 1)

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-low reset
- req0_valid  in  1  requester 0 has a write
- req0_ready  out  1  requester 0 write accepted this cycle
- req0_addr  in  5  destination register
- req0_data  in  32  write data
- req0_pc  in  32  instruction PC, for display
- req1_valid / req1_ready / req1_addr / req1_data / req1_pc  same as req0, for requester 1
- rsv_valid  in  1  issue stage reserves a destination
- rsv_addr  in  5  register reserved
- chk_a1  in  5  GRF read address 1 to check
- chk_a2  in  5  GRF read address 2 to check
- stall  out  1  read hazard on chk_a1 or chk_a2
- grfA3  out  5  GRF write address
- grfWD  out  32  GRF write data
- grfWriteEn  out  1  GRF write enable
- grfPC  out  32  PC of the committed write
- rsv_ovf  out  1  sticky: reservation dropped at counter max

Behaviour:
- Reset (reset=0, async):
  - grfWriteEn=0; grfA3=0; grfWD=0; grfPC=0.
  - All counters 0; rsv_ovf=0; rr_ptr=RR_INIT.
- Handshake and arbitration:
  - Transfer on a port when valid&&ready in the same cycle.
  - The output stage drains every cycle, so one write is always accepted per cycle.
  - Only valid0: req0_ready=1.
  - Only valid1: req1_ready=1.
  - Both valid: the requester equal to rr_ptr wins; rr_ptr flips to the loser.
  - Neither valid: rr_ptr holds; readies are 0.
  - The loser must hold valid/addr/data/pc stable until accepted.
  - Starvation bound: a continuously-valid requester waits at most 1 cycle.
- Commit (latency 1):
  - The edge after a transfer loads grfA3/grfWD/grfPC from the winner.
  - grfWriteEn=1 iff winner addr!=0. A $0 write is accepted but never enables the GRF.
  - With no transfer, grfWriteEn=0 and the other outputs hold their values.
- Scoreboard, cnt[r] for r=1..31 (cnt[0] is always 0):
  - Increment when rsv_valid && rsv_addr==r.
  - Decrement when grfWriteEn && grfA3==r (the commit cycle).
  - Increment and decrement on the same register in the same cycle: count unchanged.
  - Increment at max and no same-cycle decrement: dropped, rsv_ovf set until reset.
  - Decrement at 0: saturates at 0 (a write without reservation is legal).
- Stall (combinational from state):
  - stall = (chk_a1!=0 && cnt[chk_a1]!=0) || (chk_a2!=0 && cnt[chk_a2]!=0).
- Reset mid-operation: all in-flight transfers and reservations are discarded; nothing commits after reset release until a new transfer.

Optional Feature:
- Macro GRF_WB_ARB_BYPASS_EN.
- When defined:
  - A checked register with cnt==1 that is being committed this cycle (grfWriteEn && grfA3==chk) does not stall.
  - A second output port bypass_sel[1:0] marks which read address (bit0=a1, bit1=a2) must take grfWD instead of GRF data.
- When undefined:
  - Stall follows the base rule exactly.
  - The bypass_sel port is absent.

Decomposition:
- Shared package grf_pkg:
  - REG_AW=5, DATA_W=32, REG_NUM=32, ZERO_REG=5'd0.
  - Typedef wb_req_t {addr, data, pc}.
- One sub-module, grf_scoreboard: counters, overflow flag and stall/bypass logic.
- Arbiter, rr_ptr and the output register stay in the top.

Test Plan:
- Reset release, then req0 only (addr=5, data=32'h1234, pc=32'h3000), 3 cycles → req0_ready=1 each cycle; grfWriteEn=1, grfA3=5, grfWD=32'h1234 one cycle after each transfer.
- Both valid every cycle, RR_INIT=0 → grants alternate 0,1,0,1; each loser accepted exactly 1 cycle later; no write lost.
- req1 addr=0, data=32'hFFFF → req1_ready=1; next cycle grfWriteEn=0.
- rsv_valid addr=8, then chk_a1=8 → stall=1 until the commit cycle of the addr=8 write; stall=0 the cycle after, or during commit when GRF_WB_ARB_BYPASS_EN is defined (bypass_sel=01).
- Reserve addr=9 four times with CNT_W=2 → cnt=3, rsv_ovf=1; a same-cycle reserve+commit on addr=9 leaves cnt unchanged.
- reset pulled low mid-transfer → grfWriteEn drops to 0 immediately; stall=0; rsv_ovf=0.
